// File: rtl/bomb_controller.sv
// Per-player bomb lifecycle engine: place, fuse, blast growth and cooldown,
// all timed in synchronised frame ticks and driven straight to the colour mapper.
module bomb_controller #(
    parameter int TILE_LOG2       = 5,
    parameter int BOMB_R          = 8,
    parameter int FUSE_FRAMES     = 120,
    parameter int BLAST_STEP      = 4,
    parameter int BLAST_MAX       = 48,
    parameter int COOLDOWN_FRAMES = 30,
    parameter int PARK_XY         = 1023
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       place,
    input  logic       detonate,
    input  logic [9:0] userX,
    input  logic [9:0] userY,
    output logic [9:0] bombX,
    output logic [9:0] bombY,
    output logic [9:0] bombS,
    output logic       bomb_armed,
    output logic       blast_active,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        EXPLODE,
        COOLDOWN
    } state_t;

    localparam int FUSE_W = (FUSE_FRAMES > 1) ? $clog2(FUSE_FRAMES) : 1;
    localparam int COOL_W = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES) : 1;

    localparam logic [FUSE_W-1:0] FUSE_LAST = FUSE_W'(FUSE_FRAMES - 1);
    localparam logic [COOL_W-1:0] COOL_LAST = COOL_W'(COOLDOWN_FRAMES - 1);
    localparam logic [9:0]        PARK      = 10'(PARK_XY);
    localparam logic [9:0]        RAD_INIT  = 10'(BOMB_R);
    localparam logic [9:0]        RAD_MAX   = 10'(BLAST_MAX);
    localparam logic [10:0]       RAD_MAX11 = 11'(BLAST_MAX);
    localparam logic [10:0]       STEP11    = 11'(BLAST_STEP);
    localparam logic [9:0]        LOW_MASK  = 10'((1 << TILE_LOG2) - 1);
    localparam logic [9:0]        HALF_TILE = 10'(1 << (TILE_LOG2 - 1));

    // frame_clk synchroniser and rising-edge detector
    logic fc_meta_q, fc_sync_q, fc_prev_q;
    logic tick;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            fc_meta_q <= 1'b0;
            fc_sync_q <= 1'b0;
            fc_prev_q <= 1'b0;
        end else begin
            fc_meta_q <= frame_clk;
            fc_sync_q <= fc_meta_q;
            fc_prev_q <= fc_sync_q;
        end
    end

    assign tick = fc_sync_q & ~fc_prev_q;

    state_t             state_q, state_d;
    logic [FUSE_W-1:0]  fuse_q, fuse_d;
    logic [COOL_W-1:0]  cool_q, cool_d;
    logic [9:0]         x_q, x_d;
    logic [9:0]         y_q, y_d;
    logic [9:0]         s_q, s_d;
    logic [10:0]        grow;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            fuse_q  <= '0;
            cool_q  <= '0;
            x_q     <= PARK;
            y_q     <= PARK;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            fuse_q  <= fuse_d;
            cool_q  <= cool_d;
            x_q     <= x_d;
            y_q     <= y_d;
            s_q     <= s_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fuse_d  = fuse_q;
        cool_d  = cool_q;
        x_d     = x_q;
        y_d     = y_q;
        s_d     = s_q;
        // 11-bit sum so the radius can never wrap before clamping
        grow    = {1'b0, s_q} + STEP11;

        unique case (state_q)
            IDLE: begin
                if (place) begin
                    state_d = ARMED;
                    x_d     = (userX & ~LOW_MASK) | HALF_TILE;
                    y_d     = (userY & ~LOW_MASK) | HALF_TILE;
                    s_d     = RAD_INIT;
                    fuse_d  = '0;
                end
            end
            ARMED: begin
                if (detonate || (tick && (fuse_q == FUSE_LAST))) begin
                    state_d = EXPLODE;
                    fuse_d  = '0;
                end else if (tick) begin
                    fuse_d = fuse_q + 1'b1;
                end
            end
            EXPLODE: begin
                if (tick) begin
                    if (s_q == RAD_MAX) begin
                        state_d = COOLDOWN;
                        x_d     = PARK;
                        y_d     = PARK;
                        s_d     = '0;
                        cool_d  = '0;
                    end else if (grow >= RAD_MAX11) begin
                        s_d = RAD_MAX;
                    end else begin
                        s_d = grow[9:0];
                    end
                end
            end
            COOLDOWN: begin
                if (tick) begin
                    if (cool_q == COOL_LAST) begin
                        state_d = IDLE;
                        cool_d  = '0;
                    end else begin
                        cool_d = cool_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bombX        = x_q;
    assign bombY        = y_q;
    assign bombS        = s_q;
    assign bomb_armed   = (state_q == ARMED);
    assign blast_active = (state_q == EXPLODE);
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_bomb_controller.sv
// Randomised bench for bomb_controller, checked against a phase/tick-count
// model of the bomb lifecycle.
module tb_bomb_controller;

    localparam int TILE_LOG2       = 5;
    localparam int BOMB_R          = 8;
    localparam int FUSE_FRAMES     = 120;
    localparam int BLAST_STEP      = 4;
    localparam int BLAST_MAX       = 48;
    localparam int COOLDOWN_FRAMES = 30;
    localparam int PARK_XY         = 1023;

    localparam int P_IDLE = 0, P_ARMED = 1, P_BLAST = 2, P_COOL = 3;

    localparam logic [32:0] PARKED_IDLE = {10'd1023, 10'd1023, 10'd0, 3'b000};
    localparam logic [32:0] PARKED_COOL = {10'd1023, 10'd1023, 10'd0, 3'b001};

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       frame_clk = 1'b0;
    logic       place = 1'b0;
    logic       detonate = 1'b0;
    logic [9:0] userX = '0;
    logic [9:0] userY = '0;
    logic [9:0] bombX, bombY, bombS;
    logic       bomb_armed, blast_active, busy;
    logic [32:0] dut_out;

    int n_pass = 0;
    int n_total = 0;

    int m_ph = P_IDLE;
    int m_n = 0;
    int m_x = 0;
    int m_y = 0;
    bit f1 = 1'b0, f2 = 1'b0, f3 = 1'b0;

    bomb_controller #(
        .TILE_LOG2      (TILE_LOG2),
        .BOMB_R         (BOMB_R),
        .FUSE_FRAMES    (FUSE_FRAMES),
        .BLAST_STEP     (BLAST_STEP),
        .BLAST_MAX      (BLAST_MAX),
        .COOLDOWN_FRAMES(COOLDOWN_FRAMES),
        .PARK_XY        (PARK_XY)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_clk   (frame_clk),
        .place       (place),
        .detonate    (detonate),
        .userX       (userX),
        .userY       (userY),
        .bombX       (bombX),
        .bombY       (bombY),
        .bombS       (bombS),
        .bomb_armed  (bomb_armed),
        .blast_active(blast_active),
        .busy        (busy)
    );

    assign dut_out = {bombX, bombY, bombS, bomb_armed, blast_active, busy};

    always #10 Clk = ~Clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    function automatic int snap(input int v);
        return (v / (1 << TILE_LOG2)) * (1 << TILE_LOG2) + (1 << (TILE_LOG2 - 1));
    endfunction

    function automatic int m_radius();
        int r;
        r = BOMB_R + BLAST_STEP * m_n;
        return (r > BLAST_MAX) ? BLAST_MAX : r;
    endfunction

    function automatic logic [32:0] expect_out();
        int x, y, s;
        x = PARK_XY; y = PARK_XY; s = 0;
        if (m_ph == P_ARMED) begin
            x = m_x; y = m_y; s = BOMB_R;
        end else if (m_ph == P_BLAST) begin
            x = m_x; y = m_y; s = m_radius();
        end
        return {10'(x), 10'(y), 10'(s), (m_ph == P_ARMED), (m_ph == P_BLAST), (m_ph != P_IDLE)};
    endfunction

    task automatic model_reset();
        m_ph = P_IDLE; m_n = 0;
        f1 = 1'b0; f2 = 1'b0; f3 = 1'b0;
    endtask

    // One clock edge of the lifecycle; a tick lands three edges after frame_clk rises.
    task automatic model_edge(input bit p, input bit d);
        bit tk;
        tk = f2 && !f3;
        f3 = f2; f2 = f1; f1 = frame_clk;
        case (m_ph)
            P_IDLE: if (p) begin
                m_ph = P_ARMED; m_n = 0;
                m_x = snap(int'(userX)); m_y = snap(int'(userY));
            end
            P_ARMED: begin
                if (d) begin
                    m_ph = P_BLAST; m_n = 0;
                end else if (tk) begin
                    m_n++;
                    if (m_n == FUSE_FRAMES) begin
                        m_ph = P_BLAST; m_n = 0;
                    end
                end
            end
            P_BLAST: if (tk) begin
                if (m_radius() == BLAST_MAX) begin
                    m_ph = P_COOL; m_n = 0;
                end else m_n++;
            end
            default: if (tk) begin
                m_n++;
                if (m_n == COOLDOWN_FRAMES) begin
                    m_ph = P_IDLE; m_n = 0;
                end
            end
        endcase
    endtask

    task automatic drive(input bit p, input bit d, input bit f);
        @(negedge Clk);
        place = p; detonate = d; frame_clk = f;
        @(posedge Clk);
        model_edge(p, d);
        #1;
    endtask

    task automatic frame(input bit p, input bit d);
        repeat (4) drive(p, d, 1'b1);
        repeat (4) drive(p, d, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && m_ph != P_IDLE; i++) frame(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge Clk);
        n_total++;
        if (dut_out !== PARKED_IDLE) $display("FAIL reset_state: got %h expected %h", dut_out, PARKED_IDLE);
        else n_pass++;
        @(negedge Clk);
        Reset = 1'b1;
        model_reset();
        for (int i = 0; i < 20; i++) begin
            frame(1'b0, (i % 2) == 1);
            n_total++;
            if (dut_out !== PARKED_IDLE) $display("FAIL idle_hold f%0d: got %h expected %h", i, dut_out, PARKED_IDLE);
            else n_pass++;
        end
    endtask

    task automatic test_place();
        userX = 10'd100; userY = 10'd70;
        drive(1'b1, 1'b0, 1'b0);
        n_total++;
        if (dut_out !== {10'd112, 10'd80, 10'd8, 3'b101}) $display("FAIL place_snap: got %h expected %h", dut_out, {10'd112, 10'd80, 10'd8, 3'b101});
        else n_pass++;
        drive(1'b0, 1'b0, 1'b0);
        n_total++;
        if (dut_out !== expect_out()) $display("FAIL place_model: got %h expected %h", dut_out, expect_out());
        else n_pass++;
    endtask

    task automatic test_fuse_blast();
        for (int i = 1; i < FUSE_FRAMES; i++) begin
            frame(1'b0, 1'b0);
            n_total++;
            if (dut_out !== expect_out()) $display("FAIL fuse f%0d: got %h expected %h", i, dut_out, expect_out());
            else n_pass++;
        end
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        n_total++;
        if (bomb_armed !== 1'b1) $display("FAIL fuse_tick_latency: got armed=%b expected 1", bomb_armed);
        else n_pass++;
        drive(1'b0, 1'b0, 1'b1);
        n_total++;
        if ({blast_active, bomb_armed, bombS} !== {2'b10, 10'd8}) $display("FAIL fuse_expire: got blast=%b armed=%b S=%0d expected 1 0 8", blast_active, bomb_armed, bombS);
        else n_pass++;
        drive(1'b0, 1'b0, 1'b1);
        repeat (4) drive(1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            frame(1'b0, 1'b0);
            n_total++;
            if ({blast_active, bombS} !== {1'b1, 10'(8 + 4 * k)}) $display("FAIL blast_grow k%0d: got S=%0d expected %0d", k, bombS, 8 + 4 * k);
            else n_pass++;
        end
        frame(1'b0, 1'b0);
        n_total++;
        if (dut_out !== PARKED_COOL) $display("FAIL blast_to_cool: got %h expected %h", dut_out, PARKED_COOL);
        else n_pass++;
        for (int c = 1; c <= COOLDOWN_FRAMES; c++) begin
            frame(1'b0, 1'b0);
            n_total++;
            if (dut_out !== ((c < COOLDOWN_FRAMES) ? PARKED_COOL : PARKED_IDLE)) $display("FAIL cooldown c%0d: got %h expected %h", c, dut_out, (c < COOLDOWN_FRAMES) ? PARKED_COOL : PARKED_IDLE);
            else n_pass++;
        end
    endtask

    task automatic test_detonate();
        userX = 10'($urandom_range(0, 1023)); userY = 10'($urandom_range(0, 1023));
        drive(1'b1, 1'b0, 1'b0);
        repeat (10) frame(1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        n_total++;
        if ({blast_active, bomb_armed, bombS} !== {2'b10, 10'd8}) $display("FAIL detonate_early: got blast=%b armed=%b S=%0d expected 1 0 8", blast_active, bomb_armed, bombS);
        else n_pass++;
        n_total++;
        if (dut_out !== expect_out()) $display("FAIL detonate_model: got %h expected %h", dut_out, expect_out());
        else n_pass++;
        drain();
        n_total++;
        if (busy !== 1'b0) $display("FAIL detonate_drain: got busy=%b expected 0", busy);
        else n_pass++;

        drive(1'b1, 1'b0, 1'b0);
        repeat (FUSE_FRAMES - 1) frame(1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b1);
        n_total++;
        if ({blast_active, bombS} !== {1'b1, 10'd8}) $display("FAIL det_on_expiry: got blast=%b S=%0d expected 1 8", blast_active, bombS);
        else n_pass++;
        drive(1'b0, 1'b1, 1'b1);
        n_total++;
        if (dut_out !== expect_out()) $display("FAIL det_on_expiry_hold: got %h expected %h", dut_out, expect_out());
        else n_pass++;
        repeat (4) drive(1'b0, 1'b0, 1'b0);
        frame(1'b0, 1'b0);
        n_total++;
        if ({blast_active, bombS} !== {1'b1, 10'd12}) $display("FAIL det_single_entry: got blast=%b S=%0d expected 1 12", blast_active, bombS);
        else n_pass++;
        drain();
    endtask

    task automatic test_place_held();
        userX = 10'd799; userY = 10'($urandom_range(0, 1023));
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 300 && !(m_ph == P_COOL && m_n == COOLDOWN_FRAMES - 1); i++) begin
            frame(1'b1, 1'b0);
            n_total++;
            if (dut_out !== expect_out() || bomb_armed !== 1'b0) $display("FAIL held_place f%0d: got %h expected %h", i, dut_out, expect_out());
            else n_pass++;
        end
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        n_total++;
        if (dut_out !== PARKED_IDLE) $display("FAIL held_idle_entry: got %h expected %h", dut_out, PARKED_IDLE);
        else n_pass++;
        drive(1'b1, 1'b0, 1'b1);
        n_total++;
        if ({bomb_armed, bombX} !== {1'b1, 10'd784}) $display("FAIL held_rearm: got armed=%b X=%0d expected 1 784", bomb_armed, bombX);
        else n_pass++;
        repeat (4) drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        drain();
    endtask

    task automatic test_reset_mid_blast();
        userX = 10'($urandom_range(0, 1023)); userY = 10'($urandom_range(0, 1023));
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        repeat (5) frame(1'b0, 1'b0);
        n_total++;
        if ({blast_active, bombS} !== {1'b1, 10'd28}) $display("FAIL pre_reset_radius: got blast=%b S=%0d expected 1 28", blast_active, bombS);
        else n_pass++;
        @(negedge Clk);
        #3 Reset = 1'b0;
        #2;
        n_total++;
        if (dut_out !== PARKED_IDLE) $display("FAIL async_reset: got %h expected %h", dut_out, PARKED_IDLE);
        else n_pass++;
        model_reset();
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        n_total++;
        if (dut_out !== PARKED_IDLE) $display("FAIL reset_release: got %h expected %h", dut_out, PARKED_IDLE);
        else n_pass++;
        userX = 10'($urandom_range(0, 1023)); userY = 10'($urandom_range(0, 1023));
        drive(1'b1, 1'b0, 1'b0);
        n_total++;
        if (dut_out !== expect_out() || bomb_armed !== 1'b1) $display("FAIL place_after_reset: got %h expected %h", dut_out, expect_out());
        else n_pass++;
        drive(1'b0, 1'b1, 1'b0);
        drain();
    endtask

    task automatic test_random();
        for (int e = 0; e < 6; e++) begin
            int det_at;
            det_at = int'($urandom_range(0, FUSE_FRAMES + 10));
            userX = 10'($urandom_range(0, 1023)); userY = 10'($urandom_range(0, 1023));
            drive(1'b1, 1'b0, 1'b0);
            n_total++;
            if (dut_out !== expect_out()) $display("FAIL rand_place e%0d: got %h expected %h", e, dut_out, expect_out());
            else n_pass++;
            for (int f = 0; f < 300 && m_ph != P_IDLE; f++) begin
                frame((f < det_at) && ($urandom_range(0, 1) == 1), f == det_at);
                n_total++;
                if (dut_out !== expect_out()) $display("FAIL rand e%0d f%0d: got %h expected %h", e, f, dut_out, expect_out());
                else n_pass++;
            end
            n_total++;
            if (busy !== 1'b0) $display("FAIL rand_end e%0d: got busy=%b expected 0", e, busy);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_place();
        test_fuse_blast();
        test_detonate();
        test_place_held();
        test_reset_mid_blast();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
